mem_copy_engine: RTL and testbench
==================================

# mem_copy_engine

Memory-side initiator that moves or fills blocks of bytes in the shared 8-bit instruction/data memory without processor involvement. It drives the same address/write-enable/write-data/read-data port as the processor and expects the memory's combinational read and rising-edge write behaviour. A top-level mux selects it as memory master while `busy` is high. Typical uses: loading program images, clearing data regions and relocating tables.

## Interface
- `ADDR_W`, 8, memory address width; all address arithmetic wraps modulo 2^ADDR_W.
- `DATA_W`, 8, memory data width.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a transfer; sampled only in IDLE.
- `mode`  in  1  0 = copy, 1 = fill; sampled with `start`.
- `src`  in  ADDR_W  copy source base address; sampled with `start`.
- `dst`  in  ADDR_W  destination base address; sampled with `start`.
- `len`  in  ADDR_W  byte count; 0 = no transfer.
- `fillval`  in  DATA_W  fill byte; sampled with `start`.
- `busy`  out  1  engine owns the memory port.
- `done`  out  1  one-cycle completion pulse.
- `mem_adr`  out  ADDR_W  memory address.
- `mem_memwrite`  out  1  memory write enable.
- `mem_writedata`  out  DATA_W  memory write data.
- `mem_readdata`  in  DATA_W  memory read data; valid in the same cycle as `mem_adr`.

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE: `start`=1 at an edge latches `mode`, `src`, `dst`, `len` and `fillval`, and clears the index register `idx`.
  - `len`=0 → DONE.
  - Copy mode → READ.
  - Fill mode → WRITE.
  - `start` is ignored in every other state; there is no queueing.
- READ (copy only):
  - `mem_adr`=src+idx, `mem_memwrite`=0.
  - At the edge, `mem_readdata` is captured into the data buffer → WRITE.
- WRITE:
  - `mem_adr`=dst+idx, `mem_memwrite`=1.
  - `mem_writedata`=buffer in copy mode, or latched `fillval` in fill mode.
  - At the edge, if idx==len-1 → DONE.
  - Otherwise idx+1 → READ in copy mode, or stays in WRITE in fill mode.
- DONE: `done`=1 for exactly one cycle → IDLE.
- `busy`=1 in READ and WRITE only.
- Address sums are ADDR_W-bit and wrap (0xFF+1=0x00). `len` up to 255 is supported.
- Overlap: copy is strictly forward, byte by byte. When dst lies inside (src, src+len), already-written bytes are re-read. This is the defined behaviour, not an error.
- Port outputs decode from state and registers only; there is no combinational path from `start`/`src`/`dst`/`len` to `mem_*`.
- Outside READ/WRITE: `mem_adr`=0, `mem_memwrite`=0, `mem_writedata`=0.
- Reset, asynchronous and possibly mid-transfer:
  - State → IDLE, idx=0, buffer=0, all latched operands=0.
  - `busy`=0, `done`=0, `mem_adr`=0, `mem_memwrite`=0, `mem_writedata`=0 immediately.
  - A partial transfer is abandoned; no completion pulse.

## Timing
- Start accepted at edge E0. The first READ (copy) or WRITE (fill) cycle follows E0.
- Copy of N≥1 bytes: 2N busy cycles (READ, WRITE alternating); `done` in cycle 2N+1 after E0; IDLE again in cycle 2N+2.
- Fill of N≥1 bytes: N busy cycles; `done` in cycle N+1.
- `len`=0: `done` in the first cycle after E0; `busy` never asserts.
- A new `start` is accepted at the edge ending the IDLE cycle that follows DONE; back-to-back gap is one idle cycle minimum.
- Memory write of byte i lands at the rising edge closing WRITE cycle i. A READ in the following cycle sees the new value.

## Structure
- Shared package `mips8_mem_pkg`:
  - state enum `copy_state_t` (IDLE, READ, WRITE, DONE);
  - mode constants `MODE_COPY`=1'b0, `MODE_FILL`=1'b1;
  - default widths `MEM_ADDR_W`=8, `MEM_DATA_W`=8.
- Single flat module; no sub-module is warranted. The FSM, idx counter, buffer and operand registers fit together directly.
- The bench instantiates the existing external memory model on the `mem_*` port.

## Test plan
- Copy: preload 0x10..0x13 = AA,BB,CC,DD; start mode=0 src=0x10 dst=0x40 len=4 → 0x40..0x43 = AA,BB,CC,DD; busy for 8 cycles; done in cycle 9; source unchanged.
- Fill: mode=1 dst=0x80 len=3 fillval=0x5A → 0x80..0x82 = 5A; 0x83 untouched; busy for 3 cycles; done in cycle 4.
- Wrap and overlap:
  - fill dst=0xFE len=4 fillval=0x11 → 0xFE,0xFF,0x00,0x01 = 11.
  - copy src=0x20 dst=0x21 len=3 with 0x20=7E → 0x21..0x23 = 7E.
- len=0 → no write strobe, busy never high, done one cycle after start; start held high during a busy transfer is ignored, with no second done.
- reset_n low during cycle 3 of a 4-byte copy → outputs zero immediately; only byte 0 written; after release, a fresh start completes normally.

Source files
------------

// File: rtl/mips8_mem_pkg.sv
// Shared definitions for the mips8 memory-side blocks.
//   copy_state_t : copy/fill engine FSM states
//   MODE_COPY / MODE_FILL : transfer mode encoding on the 'mode' input
//   MEM_ADDR_W / MEM_DATA_W : default memory port widths
package mips8_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } copy_state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 8;

endpackage

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: memory-side initiator that copies or fills a block of
// bytes on the shared memory port (combinational read, rising-edge write).
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   start, mode             transfer request (sampled in IDLE), 0=copy 1=fill
//   src, dst, len, fillval  transfer operands, latched with start
//   busy                    engine owns the memory port (READ/WRITE)
//   done                    one-cycle completion pulse
//   mem_adr, mem_memwrite,
//   mem_writedata           memory master outputs
//   mem_readdata            memory read data for mem_adr, same cycle
//
// state | meaning
// IDLE  | waiting for start; port outputs parked at zero
// READ  | copy only: drive src+idx, capture read data into buffer
// WRITE | drive dst+idx with buffer (copy) or fill byte (fill)
// DONE  | single-cycle done pulse, back to IDLE
module mem_copy_engine
    import mips8_mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W-1:0] len,
    input  logic [DATA_W-1:0] fillval,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_adr,
    output logic              mem_memwrite,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata
);

    copy_state_t       r_state;
    copy_state_t       w_next;

    logic              r_mode;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [ADDR_W-1:0] r_len;
    logic [DATA_W-1:0] r_fill;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_buf;

    logic              w_last;

    // r_len is never zero while in WRITE, so len-1 does not underflow here.
    assign w_last = (r_idx == (r_len - ADDR_W'(1)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and port decode; outputs depend only on registered state.
    always_comb begin
        w_next        = r_state;
        busy          = 1'b0;
        done          = 1'b0;
        mem_adr       = '0;
        mem_memwrite  = 1'b0;
        mem_writedata = '0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (len == '0)
                        w_next = DONE;
                    else if (mode == MODE_FILL)
                        w_next = WRITE;
                    else
                        w_next = READ;
                end
            end
            READ: begin
                busy    = 1'b1;
                mem_adr = r_src + r_idx;
                w_next  = WRITE;
            end
            WRITE: begin
                busy          = 1'b1;
                mem_adr       = r_dst + r_idx;
                mem_memwrite  = 1'b1;
                mem_writedata = (r_mode == MODE_FILL) ? r_fill : r_buf;
                if (w_last)
                    w_next = DONE;
                else if (r_mode == MODE_FILL)
                    w_next = WRITE;
                else
                    w_next = READ;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode <= MODE_COPY;
            r_src  <= '0;
            r_dst  <= '0;
            r_len  <= '0;
            r_fill <= '0;
            r_idx  <= '0;
            r_buf  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mode <= mode;
                        r_src  <= src;
                        r_dst  <= dst;
                        r_len  <= len;
                        r_fill <= fillval;
                        r_idx  <= '0;
                    end
                end
                READ: begin
                    r_buf <= mem_readdata;
                end
                WRITE: begin
                    if (!w_last)
                        r_idx <= r_idx + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
module tb_mem_copy_engine;
    import mips8_mem_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       mode;
    logic [7:0] src, dst, len, fillval;
    logic       busy, done, mem_memwrite;
    logic [7:0] mem_adr, mem_writedata, mem_readdata;

    logic [7:0] mem  [256];
    logic [7:0] refm [256];

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_copy_engine #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .mode          (mode),
        .src           (src),
        .dst           (dst),
        .len           (len),
        .fillval       (fillval),
        .busy          (busy),
        .done          (done),
        .mem_adr       (mem_adr),
        .mem_memwrite  (mem_memwrite),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata)
    );

    // Memory: combinational read, rising-edge write.
    assign mem_readdata = mem[mem_adr];
    always @(posedge clk) begin
        if (mem_memwrite) mem[mem_adr] <= mem_writedata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: forward byte-by-byte transfer, addresses wrap at 256.
    task automatic ref_xfer(input logic m, input logic [7:0] s, input logic [7:0] d,
                            input int l, input logic [7:0] f);
        for (int i = 0; i < l; i++)
            refm[8'(d + i)] = (m == MODE_FILL) ? f : refm[8'(s + i)];
    endtask

    task automatic compare_mem(input string tag);
        int nm = 0;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== refm[i]) nm++;
        check(tag, nm, 0);
    endtask

    // Issue one transfer; cycle k = k-th cycle after the accepting edge.
    task automatic run(input logic m, input logic [7:0] s, input logic [7:0] d,
                       input logic [7:0] l, input logic [7:0] f, input bit hold,
                       output int busy_n, output int done_at,
                       output int writes, output int dones);
        @(negedge clk);
        start = 1'b1; mode = m; src = s; dst = d; len = l; fillval = f;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        // operands must have been latched; scramble the inputs
        mode = 1'($urandom); src = 8'($urandom); dst = 8'($urandom);
        len = 8'($urandom); fillval = 8'($urandom);
        busy_n = 0; done_at = 0; writes = 0; dones = 0;
        for (int k = 1; k <= 700; k++) begin
            if (busy) busy_n++;
            if (mem_memwrite) writes++;
            if (done) begin
                dones++;
                if (done_at == 0) done_at = k;
                start = 1'b0;
            end
            if (done_at != 0 && k >= done_at + 3) break;
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic xfer_checked(input string tag, input logic m, input logic [7:0] s,
                                input logic [7:0] d, input logic [7:0] l,
                                input logic [7:0] f, input bit hold);
        int b, da, w, dn, n;
        n = int'(l);
        run(m, s, d, l, f, hold, b, da, w, dn);
        ref_xfer(m, s, d, n, f);
        check({tag, "_busy"},   b,  (m == MODE_FILL) ? n : 2 * n);
        check({tag, "_done_at"}, da, (n == 0) ? 1 : ((m == MODE_FILL) ? n + 1 : 2 * n + 1));
        check({tag, "_writes"}, w,  n);
        check({tag, "_dones"},  dn, 1);
        check({tag, "_idle_port"}, {busy, mem_memwrite, mem_adr, mem_writedata}, 0);
        compare_mem({tag, "_mem"});
    endtask

    initial begin
        logic [7:0] pre83;
        logic [7:0] rs, rd, rl, rf;
        logic       rm;
        bit         saw_done;

        reset_n = 1'b0; start = 1'b0; mode = 1'b0;
        src = '0; dst = '0; len = '0; fillval = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 8'($urandom);
            refm[i] = mem[i];
        end
        #12;
        check("reset_outputs", {busy, done, mem_memwrite, mem_adr, mem_writedata}, 0);
        @(negedge clk); reset_n = 1'b1;

        // Directed copy
        mem[8'h10] = 8'hAA; mem[8'h11] = 8'hBB; mem[8'h12] = 8'hCC; mem[8'h13] = 8'hDD;
        for (int i = 8'h10; i <= 8'h13; i++) refm[i] = mem[i];
        xfer_checked("copy4", MODE_COPY, 8'h10, 8'h40, 8'd4, 8'h00, 1'b0);
        check("copy4_dst", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]}, 32'hAABBCCDD);
        check("copy4_src", {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]}, 32'hAABBCCDD);

        // Directed fill
        pre83 = mem[8'h83];
        xfer_checked("fill3", MODE_FILL, 8'h00, 8'h80, 8'd3, 8'h5A, 1'b0);
        check("fill3_dst", {mem[8'h80], mem[8'h81], mem[8'h82]}, 24'h5A5A5A);
        check("fill3_after", mem[8'h83], pre83);

        // Wrap
        xfer_checked("fillwrap", MODE_FILL, 8'h00, 8'hFE, 8'd4, 8'h11, 1'b0);
        check("fillwrap_dst", {mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]}, 32'h11111111);

        // Forward overlap
        mem[8'h20] = 8'h7E; refm[8'h20] = 8'h7E;
        xfer_checked("overlap", MODE_COPY, 8'h20, 8'h21, 8'd3, 8'h00, 1'b0);
        check("overlap_dst", {mem[8'h21], mem[8'h22], mem[8'h23]}, 24'h7E7E7E);

        // len=0, then start held high across a busy transfer
        xfer_checked("len0", MODE_COPY, 8'h10, 8'h50, 8'd0, 8'h00, 1'b0);
        xfer_checked("hold", MODE_COPY, 8'h40, 8'h90, 8'd3, 8'h00, 1'b1);

        // Full-length copy
        xfer_checked("len255", MODE_COPY, 8'h05, 8'h00, 8'd255, 8'h00, 1'b0);

        // Reset in cycle 3 of a 4-byte copy
        @(negedge clk);
        start = 1'b1; mode = MODE_COPY; src = 8'h30; dst = 8'h60; len = 8'd4;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_pre_adr", {busy, mem_memwrite, mem_adr}, {1'b1, 1'b0, 8'h31});
        reset_n = 1'b0; #1;
        check("rst_outputs", {busy, done, mem_memwrite, mem_adr, mem_writedata}, 0);
        saw_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        @(negedge clk); reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        check("rst_no_done", saw_done, 1'b0);
        refm[8'h60] = refm[8'h30];
        compare_mem("rst_partial_mem");
        xfer_checked("rst_fresh", MODE_COPY, 8'h30, 8'h60, 8'd4, 8'h00, 1'b0);

        // Random transfers
        for (int t = 0; t < 24; t++) begin
            rm = 1'($urandom);
            rs = 8'($urandom);
            rd = 8'($urandom);
            rl = 8'($urandom_range(0, 48));
            rf = 8'($urandom);
            xfer_checked($sformatf("rnd%0d", t), rm, rs, rd, rl, rf, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
